// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller: default geometry
// and the controller state encoding.
package regfile_pkg;

  localparam int DEF_NREG   = 8;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_addr_decode.sv
// Address to one-hot enable decoder for the cell array. The enable vector is
// all zero when disabled or when the address falls outside the populated range.
module regfile_addr_decode #(
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [NREG-1:0]   o_onehot,
  output logic              o_in_range
);

  // One extra bit so NREG == 2**ADDR_W still compares correctly
  assign o_in_range = ({1'b0, i_addr} < (ADDR_W+1)'(NREG));

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_en && (i_addr == ADDR_W'(i))) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator for the register-file cell control bus: turns valid/ready read and
// write requests into registered one-hot cell enables and returns read data.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data_a,
  output logic [WIDTH-1:0]  rsp_data_b,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [NREG-1:0]   we,
  output logic [WIDTH-1:0]  wbus,
  output logic [NREG-1:0]   re_a,
  output logic [NREG-1:0]   re_b,
  input  logic [WIDTH-1:0]  rbus_a,
  input  logic [WIDTH-1:0]  rbus_b
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [NREG-1:0]   r_we;
  logic [NREG-1:0]   r_re_a;
  logic [NREG-1:0]   r_re_b;
  logic [WIDTH-1:0]  r_wbus;
  logic [WIDTH-1:0]  r_rsp_data_a;
  logic [WIDTH-1:0]  r_rsp_data_b;
  logic              r_rsp_err;
  logic              r_err_sticky;
  logic              r_ok_a;
  logic              r_ok_b;

  logic              w_hs;
  logic [NREG-1:0]   w_we_dec;
  logic [NREG-1:0]   w_re_a_dec;
  logic [NREG-1:0]   w_re_b_dec;
  logic              w_wr_in_range;
  logic              w_rd_in_range_a;
  logic              w_rd_in_range_b;
  logic              w_req_err;
  logic              w_req_ready_nxt;
  logic              w_rsp_valid_nxt;

  assign w_hs = req_valid & r_req_ready;

  // Enables are decoded straight from the request and registered at the
  // handshake edge, so they are high for exactly the WRITE/READ cycle.
  regfile_addr_decode #(.NREG(NREG), .ADDR_W(ADDR_W)) u_dec_we (
    .i_addr     (req_addr_a),
    .i_en       (w_hs & req_write),
    .o_onehot   (w_we_dec),
    .o_in_range (w_wr_in_range)
  );

  regfile_addr_decode #(.NREG(NREG), .ADDR_W(ADDR_W)) u_dec_re_a (
    .i_addr     (req_addr_a),
    .i_en       (w_hs & ~req_write),
    .o_onehot   (w_re_a_dec),
    .o_in_range (w_rd_in_range_a)
  );

  regfile_addr_decode #(.NREG(NREG), .ADDR_W(ADDR_W)) u_dec_re_b (
    .i_addr     (req_addr_b),
    .i_en       (w_hs & ~req_write),
    .o_onehot   (w_re_b_dec),
    .o_in_range (w_rd_in_range_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next_state = req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: w_next_state = ST_IDLE;
      ST_READ:  w_next_state = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they stay low in reset
  always_comb begin
    w_req_ready_nxt = (w_next_state == ST_IDLE);
    w_rsp_valid_nxt = (w_next_state == ST_RESP);
    w_req_err       = req_write ? ~w_wr_in_range
                                : ~(w_rd_in_range_a & w_rd_in_range_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_we         <= '0;
      r_re_a       <= '0;
      r_re_b       <= '0;
      r_wbus       <= '0;
      r_rsp_data_a <= '0;
      r_rsp_data_b <= '0;
      r_rsp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_ok_a       <= 1'b0;
      r_ok_b       <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_we        <= w_we_dec;
      r_re_a      <= w_re_a_dec;
      r_re_b      <= w_re_b_dec;
      if (w_hs && req_write) begin
        r_wbus <= req_wdata;
      end
      if (w_hs && !req_write) begin
        r_ok_a <= w_rd_in_range_a;
        r_ok_b <= w_rd_in_range_b;
      end
      if (w_hs && w_req_err) begin
        r_err_sticky <= 1'b1;
      end
      // An unselected port's bus is floating, so it is never sampled
      if (r_state == ST_READ) begin
        r_rsp_data_a <= r_ok_a ? rbus_a : '0;
        r_rsp_data_b <= r_ok_b ? rbus_b : '0;
        r_rsp_err    <= ~(r_ok_a & r_ok_b);
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data_a = r_rsp_data_a;
  assign rsp_data_b = r_rsp_data_b;
  assign rsp_err    = r_rsp_err;
  assign err_sticky = r_err_sticky;
  assign we         = r_we;
  assign wbus       = r_wbus;
  assign re_a       = r_re_a;
  assign re_b       = r_re_b;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a six-cell array model, a directed vector
// table, a reset-during-read sequence and randomized traffic against a model.
module tb_regfile_access_ctrl;

  localparam int NREG   = 6;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr_a = '0;
  logic [ADDR_W-1:0] req_addr_b = '0;
  logic [WIDTH-1:0]  req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [WIDTH-1:0]  rsp_data_a;
  logic [WIDTH-1:0]  rsp_data_b;
  logic              rsp_err;
  logic              err_sticky;
  logic [NREG-1:0]   we;
  logic [WIDTH-1:0]  wbus;
  logic [NREG-1:0]   re_a;
  logic [NREG-1:0]   re_b;
  logic [WIDTH-1:0]  rbus_a;
  logic [WIDTH-1:0]  rbus_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [WIDTH-1:0]  d;
    int                stall;
    logic [NREG-1:0]   eWe;
    logic [NREG-1:0]   eReA;
    logic [NREG-1:0]   eReB;
    logic [WIDTH-1:0]  eDa;
    logic [WIDTH-1:0]  eDb;
    logic              eErr;
    logic              eSticky;
  } vec_t;

  vec_t vecs[9];

  logic [WIDTH-1:0] cells [NREG] = '{default: '0};
  logic [WIDTH-1:0] model [NREG];
  logic             modelSticky;
  logic [WIDTH-1:0] junkA = 8'h3C;
  logic [WIDTH-1:0] junkB = 8'hC3;

  regfile_access_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky),
    .we         (we),
    .wbus       (wbus),
    .re_a       (re_a),
    .re_b       (re_b),
    .rbus_a     (rbus_a),
    .rbus_b     (rbus_b)
  );

  always #5 clk = ~clk;

  // Cell array: write on enable, drive the shared bus only when selected
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (we[i]) cells[i] <= wbus;
    end
  end

  always @(negedge clk) begin
    junkA <= 8'($urandom);
    junkB <= 8'($urandom);
  end

  always_comb begin
    rbus_a = junkA;
    rbus_b = junkB;
    for (int i = 0; i < NREG; i++) begin
      if (re_a[i]) rbus_a = cells[i];
      if (re_b[i]) rbus_b = cells[i];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(we) > 1 || $countones(re_a) > 1 || $countones(re_b) > 1 ||
          (we != '0 && (re_a | re_b) != '0)) begin
        errors++;
        $display("[TB] FAIL enable_invariant: we=%b re_a=%b re_b=%b at %0t", we, re_a, re_b, $time);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("req_ready_wait", req_ready, 1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_addr_a = v.a;
    req_addr_b = v.b;
    req_wdata  = v.d;
    rsp_ready  = 1'b0;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr_a = ADDR_W'($urandom);
    req_addr_b = ADDR_W'($urandom);
    req_wdata  = WIDTH'($urandom);
    checkOutput("err_sticky", err_sticky, v.eSticky);
    checkOutput("req_ready_busy", req_ready, 0);
    checkOutput("rsp_valid_early", rsp_valid, 0);
    if (v.wr) begin
      checkOutput("we", we, v.eWe);
      checkOutput("wbus", wbus, v.d);
      checkOutput("re_during_write", re_a | re_b, 0);
      @(posedge clk); #1;
      checkOutput("we_one_cycle", we, 0);
      checkOutput("req_ready_after_write", req_ready, 1);
      checkOutput("rsp_valid_write", rsp_valid, 0);
    end else begin
      checkOutput("re_a", re_a, v.eReA);
      checkOutput("re_b", re_b, v.eReB);
      checkOutput("we_during_read", we, 0);
      @(posedge clk); #1;
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_data_a", rsp_data_a, v.eDa);
      checkOutput("rsp_data_b", rsp_data_b, v.eDb);
      checkOutput("rsp_err", rsp_err, v.eErr);
      checkOutput("re_one_cycle", re_a | re_b, 0);
      repeat (v.stall) begin
        @(posedge clk); #1;
        checkOutput("stall_rsp_valid", rsp_valid, 1);
        checkOutput("stall_data_a", rsp_data_a, v.eDa);
        checkOutput("stall_data_b", rsp_data_b, v.eDb);
        checkOutput("stall_err", rsp_err, v.eErr);
        checkOutput("stall_req_ready", req_ready, 0);
        checkOutput("stall_enables", {we, re_a, re_b}, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_drop", rsp_valid, 0);
      checkOutput("req_ready_after_rsp", req_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int gap;

    vecs[0] = '{1'b1, 3'd3, 3'd0, 8'h5A, 0, 6'b001000, 6'b000000, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd3, 3'd0, 8'h00, 4, 6'b000000, 6'b001000, 6'b000001, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 3'd0, 8'h33, 0, 6'b000000, 6'b000000, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 3'd7, 3'd2, 8'h00, 0, 6'b000000, 6'b000000, 6'b000100, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'd1, 3'd0, 8'hA5, 0, 6'b000010, 6'b000000, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 3'd1, 3'd1, 8'h00, 0, 6'b000000, 6'b000010, 6'b000010, 8'hA5, 8'hA5, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 3'd5, 3'd0, 8'hC3, 0, 6'b100000, 6'b000000, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'd5, 3'd6, 8'h00, 0, 6'b000000, 6'b100000, 6'b000000, 8'hC3, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 3'd6, 3'd5, 8'h00, 1, 6'b000000, 6'b000000, 6'b100000, 8'h00, 8'hC3, 1'b1, 1'b1};

    #12;
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_err_sticky", err_sticky, 0);
    checkOutput("reset_enables", {we, re_a, re_b}, 0);
    checkOutput("reset_wbus", wbus, 0);
    checkOutput("reset_rsp_data", {rsp_data_a, rsp_data_b}, 0);
    #5 rst_n = 1'b1;
    #1 checkOutput("ready_before_first_edge", req_ready, 0);
    @(posedge clk); #1;
    checkOutput("ready_after_first_edge", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset while a read is in flight: enables must drop without a clock
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr_a = 3'd1;
    req_addr_b = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("midreset_re_a_before", re_a, 6'b000010);
    checkOutput("midreset_re_b_before", re_b, 6'b100000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_re_a", re_a, 0);
    checkOutput("midreset_re_b", re_b, 0);
    checkOutput("midreset_req_ready", req_ready, 0);
    checkOutput("midreset_sticky", err_sticky, 0);
    @(posedge clk); #1;
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postreset_req_ready", req_ready, 1);
    v = '{1'b0, 3'd1, 3'd5, 8'h00, 0, 6'b000000, 6'b000010, 6'b100000, 8'hA5, 8'hC3, 1'b0, 1'b0};
    applyStimulus(v);

    model = '{8'h00, 8'hA5, 8'h00, 8'h5A, 8'h00, 8'hC3};
    modelSticky = 1'b0;
    for (int n = 0; n < 80; n++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.a     = ADDR_W'($urandom_range(0, 7));
      v.b     = ADDR_W'($urandom_range(0, 7));
      v.d     = WIDTH'($urandom);
      v.stall = $urandom_range(0, 3);
      v.eWe   = '0;
      v.eReA  = '0;
      v.eReB  = '0;
      v.eDa   = '0;
      v.eDb   = '0;
      if (v.wr && v.a < NREG) v.eWe = NREG'(1 << v.a);
      if (!v.wr && v.a < NREG) begin
        v.eReA = NREG'(1 << v.a);
        v.eDa  = model[v.a];
      end
      if (!v.wr && v.b < NREG) begin
        v.eReB = NREG'(1 << v.b);
        v.eDb  = model[v.b];
      end
      v.eErr = !v.wr && (v.a >= NREG || v.b >= NREG);
      if (v.wr ? (v.a >= NREG) : v.eErr) modelSticky = 1'b1;
      v.eSticky = modelSticky;
      if (v.wr && v.a < NREG) model[v.a] = v.d;
      applyStimulus(v);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("cell_%0d_final", i), cells[i], model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
